// File: rtl/score_bcd_digitizer_if.sv
// score_bcd_digitizer_if: operand inputs and BCD result outputs of the score digitizer
interface score_bcd_digitizer_if #(
    parameter int DIGITS = 5,
    parameter int WIDTH  = 16
);
    logic [WIDTH-1:0]    score;
    logic [WIDTH-1:0]    maxScore;
    logic [4*DIGITS-1:0] scoreDigits;
    logic [4*DIGITS-1:0] maxDigits;
    logic [DIGITS-1:0]   scoreBlank;
    logic [DIGITS-1:0]   maxBlank;
    logic                scoreUpd;
    logic                maxUpd;

    modport master (
        output score, maxScore,
        input  scoreDigits, maxDigits, scoreBlank, maxBlank, scoreUpd, maxUpd
    );

    modport slave (
        input  score, maxScore,
        output scoreDigits, maxDigits, scoreBlank, maxBlank, scoreUpd, maxUpd
    );
endinterface

// File: rtl/score_bcd_digitizer.sv
// score_bcd_digitizer: round-robin double-dabble conversion of score/maxScore to blanked BCD
module score_bcd_digitizer #(
    parameter int DIGITS = 5,
    parameter int WIDTH  = 16
) (
    input logic                      clk,
    input logic                      resetN,
    score_bcd_digitizer_if.slave     bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);
    localparam logic [DIGITS-1:0] BLANK_ZERO = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            r_state, w_next;
    logic              r_sel;
    logic [WIDTH-1:0]  r_bin;
    logic [BW-1:0]     r_bcd;
    logic [CW-1:0]     r_cnt;
    logic [BW-1:0]     r_score_digits, r_max_digits;
    logic [DIGITS-1:0] r_score_blank, r_max_blank;
    logic              r_score_upd, r_max_upd;
    logic [BW-1:0]     w_adj;
    logic [DIGITS-1:0] w_blank;
    logic [WIDTH-1:0]  w_op;

    assign w_op = r_sel ? bus.maxScore : bus.score;

    assign bus.scoreDigits = r_score_digits;
    assign bus.maxDigits   = r_max_digits;
    assign bus.scoreBlank  = r_score_blank;
    assign bus.maxBlank    = r_max_blank;
    assign bus.scoreUpd    = r_score_upd;
    assign bus.maxUpd      = r_max_upd;

    // State register; reset always restarts from IDLE
    always_ff @(posedge clk) begin
        r_state <= !resetN ? IDLE : w_next;
    end

    // Next state: free-running LOAD -> 16x SHIFT -> DONE loop
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = LOAD;
            LOAD:    w_next = SHIFT;
            SHIFT:   w_next = (r_cnt == '0) ? DONE : SHIFT;
            default: w_next = LOAD;
        endcase
    end

    // Per-digit add-3 correction applied before each shift; no inter-digit carry
    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < DIGITS; k++)
            w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3 : r_bcd[4*k +: 4];
    end

    // Digit i is blank when it and every more significant digit are zero; ones digit never blanks
    always_comb begin
        w_blank = '0;
        for (int k = 1; k < DIGITS; k++)
            w_blank[k] = (r_bcd >> (4 * k)) == '0;
    end

    // Conversion datapath and atomic publish of the finished operand
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_sel          <= 1'b0;
            r_bin          <= '0;
            r_bcd          <= '0;
            r_cnt          <= '0;
            r_score_digits <= '0;
            r_max_digits   <= '0;
            r_score_blank  <= BLANK_ZERO;
            r_max_blank    <= BLANK_ZERO;
            r_score_upd    <= 1'b0;
            r_max_upd      <= 1'b0;
        end else begin
            r_score_upd <= 1'b0;
            r_max_upd   <= 1'b0;
            case (r_state)
                LOAD: begin
                    r_bin <= w_op[WIDTH-1] ? '0 : w_op;
                    r_bcd <= '0;
                    r_cnt <= CW'(WIDTH - 1);
                end
                SHIFT: begin
                    r_bcd <= {w_adj[BW-2:0], r_bin[WIDTH-1]};
                    r_bin <= {r_bin[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt - 1'b1;
                end
                DONE: begin
                    if (r_sel) begin
                        r_max_digits <= r_bcd;
                        r_max_blank  <= w_blank;
                        r_max_upd    <= 1'b1;
                    end else begin
                        r_score_digits <= r_bcd;
                        r_score_blank  <= w_blank;
                        r_score_upd    <= 1'b1;
                    end
                    r_sel <= ~r_sel;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_score_bcd_digitizer.sv
// tb_score_bcd_digitizer: directed vector table plus reset/capture corner sequences
module tb_score_bcd_digitizer;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   n;

    score_bcd_digitizer_if bus();

    score_bcd_digitizer dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic [15:0] m;
        logic [19:0] sd;
        logic [19:0] md;
        logic [4:0]  sb;
        logic [4:0]  mb;
    } vec_t;

    vec_t v[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_upd(input bit mx, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(mx ? bus.maxUpd : bus.scoreUpd) && cyc < 200);
    endtask

    task automatic pulse_reset(input int cyc);
        resetN = 1'b0;
        repeat (cyc) @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        v[0] = '{16'd0,     16'd0,     20'h00000, 20'h00000, 5'b11110, 5'b11110};
        v[1] = '{16'd1234,  16'd905,   20'h01234, 20'h00905, 5'b10000, 5'b11000};
        v[2] = '{16'd32767, 16'd10000, 20'h32767, 20'h10000, 5'b00000, 5'b00000};
        v[3] = '{16'hFFFB,  16'd7,     20'h00000, 20'h00007, 5'b11110, 5'b11110};
        v[4] = '{16'd5555,  16'h8000,  20'h05555, 20'h00000, 5'b10000, 5'b11110};
        v[5] = '{16'd9,     16'd59,    20'h00009, 20'h00059, 5'b11110, 5'b11100};

        bus.score    = '0;
        bus.maxScore = '0;
        resetN       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sd", bus.scoreDigits, 20'h00000);
        chk("rst_md", bus.maxDigits, 20'h00000);
        chk("rst_sb", bus.scoreBlank, 5'b11110);
        chk("rst_mb", bus.maxBlank, 5'b11110);
        chk("rst_su", bus.scoreUpd, 1'b0);
        chk("rst_mu", bus.maxUpd, 1'b0);
        resetN = 1'b1;

        for (int i = 0; i < 6; i++) begin
            bus.score    = v[i].s;
            bus.maxScore = v[i].m;
            pulse_reset(1);
            wait_upd(1'b0, n);
            chk($sformatf("v%0d_s_lat", i), n, 19);
            chk($sformatf("v%0d_sd", i), bus.scoreDigits, v[i].sd);
            chk($sformatf("v%0d_sb", i), bus.scoreBlank, v[i].sb);
            chk($sformatf("v%0d_mu_lo", i), bus.maxUpd, 1'b0);
            wait_upd(1'b1, n);
            chk($sformatf("v%0d_m_lat", i), n, 18);
            chk($sformatf("v%0d_md", i), bus.maxDigits, v[i].md);
            chk($sformatf("v%0d_mb", i), bus.maxBlank, v[i].mb);
            chk($sformatf("v%0d_su_lo", i), bus.scoreUpd, 1'b0);
            chk($sformatf("v%0d_sd_hold", i), bus.scoreDigits, v[i].sd);
        end

        bus.score    = 16'd42;
        bus.maxScore = 16'd0;
        pulse_reset(1);
        repeat (2) @(negedge clk);
        bus.score = 16'd77;
        wait_upd(1'b0, n);
        chk("chg_lat1", n, 17);
        chk("chg_sd1", bus.scoreDigits, 20'h00042);
        wait_upd(1'b0, n);
        chk("chg_lat2", n, 36);
        chk("chg_sd2", bus.scoreDigits, 20'h00077);

        bus.score    = 16'd1234;
        bus.maxScore = 16'd500;
        pulse_reset(1);
        wait_upd(1'b0, n);
        wait_upd(1'b1, n);
        chk("mid_md_pre", bus.maxDigits, 20'h00500);
        wait_upd(1'b0, n);
        repeat (8) @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        chk("mid_sd", bus.scoreDigits, 20'h00000);
        chk("mid_md", bus.maxDigits, 20'h00000);
        chk("mid_sb", bus.scoreBlank, 5'b11110);
        chk("mid_mb", bus.maxBlank, 5'b11110);
        resetN = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.scoreUpd || bus.maxUpd) && n < 200);
        chk("mid_lat", n, 19);
        chk("mid_su", bus.scoreUpd, 1'b1);
        chk("mid_mu", bus.maxUpd, 1'b0);
        chk("mid_sd_new", bus.scoreDigits, 20'h01234);
        chk("mid_md_kept", bus.maxDigits, 20'h00000);
        @(negedge clk);
        chk("mid_su_pulse", bus.scoreUpd, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
